// File: rtl/cla_addsub_pipe_pkg.sv
// Shared constants, stage-1 payload type and the carry-lookahead function
// used by both lookahead levels of cla_addsub_pipe.
// No ports: compile-time definitions only.
package cla_pkg;

  localparam int CLA_BLOCK  = 4;
  localparam int CLA_MAX_NB = 8;
  // Largest datapath the payload struct can carry (8 blocks of up to 8 bits).
  localparam int CLA_MAX_W  = CLA_MAX_NB * CLA_MAX_NB;

  // Stage-1 payload. It is sized for the largest legal configuration.
  // Bits above the configured WIDTH/NB are always zero.
  typedef struct packed {
    logic [CLA_MAX_W-1:0]  p;      // bit propagate a ^ b'
    logic [CLA_MAX_W-1:0]  g;      // bit generate  a & b'
    logic [CLA_MAX_NB-1:0] grp_p;  // per-block group propagate
    logic [CLA_MAX_NB-1:0] grp_g;  // per-block group generate
    logic                  c0;     // conditioned carry-in
  } s1_pay_t;

  // Lookahead carries c[0..CLA_MAX_NB] for a propagate/generate vector.
  // c[0] is cin. Each c[k] is built as a flat sum of products:
  //   c[k] = cin & p[0..k-1]  |  OR_j ( g[j] & p[j+1..k-1] )
  // No carry term depends on a previously computed carry, so nothing ripples.
  // Unused high inputs must be tied to zero. The matching outputs are ignored.
  function automatic logic [CLA_MAX_NB:0] cla_carries(
    input logic [CLA_MAX_NB-1:0] p,
    input logic [CLA_MAX_NB-1:0] g,
    input logic                  cin
  );
    logic [CLA_MAX_NB:0] c;
    logic                term;
    for (int k = 0; k <= CLA_MAX_NB; k++) begin
      term = cin;
      for (int j = 0; j < k; j++) term = term & p[j];
      c[k] = term;
      for (int j = 0; j < k; j++) begin
        term = g[j];
        for (int m = j + 1; m < k; m++) term = term & p[m];
        c[k] = c[k] | term;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_addsub_pipe_if.sv
// Stream bundle for cla_addsub_pipe: operand beat in, result beat out.
// Ports (signals): in_valid/in_ready/in_a/in_b/in_cin/in_sub, out_valid/out_ready/out_sum/out_cout/out_ovf.
// master = producer of operands and consumer of results; slave = the adder.
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_addsub_pipe_block4.sv
// First-level lookahead block: in-block carries plus group propagate and group generate.
// Ports: p_i/g_i bit propagate/generate, cin_i block carry-in; c_o carry into each bit, grp_p_o/grp_g_o.
// Purely combinational, with no latency and no backpressure.
module cla_block4
  import cla_pkg::*;
#(
  parameter int BLOCK = CLA_BLOCK
) (
  input  logic [BLOCK-1:0] p_i,
  input  logic [BLOCK-1:0] g_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] c_o,
  output logic             grp_p_o,
  output logic             grp_g_o
);

  logic [CLA_MAX_NB-1:0] p_pad;
  logic [CLA_MAX_NB-1:0] g_pad;
  logic [CLA_MAX_NB:0]   c_all;
  logic [CLA_MAX_NB:0]   gen_all;
  logic                  unused_hi;

  assign p_pad = CLA_MAX_NB'(p_i);
  assign g_pad = CLA_MAX_NB'(g_i);

  assign c_all   = cla_carries(p_pad, g_pad, cin_i);
  // Group generate is the block carry-out with a zero carry-in.
  assign gen_all = cla_carries(p_pad, g_pad, 1'b0);

  assign c_o     = c_all[BLOCK-1:0];
  assign grp_p_o = &p_i;
  assign grp_g_o = gen_all[BLOCK];

  assign unused_hi = ^{c_all[CLA_MAX_NB:BLOCK], gen_all};

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor. Ports: clk, rst_n, and bus (slave).
// Latency: a beat is captured into stage 1 at its accept edge, and the result is valid after the next edge.
// Backpressure: out regs hold while out_valid & !out_ready. in_ready drops only when both stages are full.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = CLA_BLOCK
) (
  input  logic              clk,
  input  logic              rst_n,
  cla_addsub_pipe_if.slave  bus
);

  // WIDTH must be a multiple of BLOCK, with 1 <= NB <= CLA_MAX_NB and BLOCK <= CLA_MAX_NB.
  localparam int NB = WIDTH / BLOCK;

  logic             adv1;
  logic             adv2;
  logic             s1_valid_q;
  s1_pay_t          s1_q;
  s1_pay_t          s1_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q,  out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q,  out_ovf_d;

  // ---------------- handshake ----------------
  assign adv2         = !out_valid_q | bus.out_ready;
  assign adv1         = !s1_valid_q | adv2;
  assign bus.in_ready = adv1;

  // ---------------- stage 1: conditioning + bit/group P,G ----------------
  // Subtraction is A + ~B + ~borrow, so the borrow-in is inverted into c0.
  logic [WIDTH-1:0] b_cond;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic             c0_in;
  logic [NB-1:0]    grp_p_in;
  logic [NB-1:0]    grp_g_in;

  assign b_cond = bus.in_sub ? ~bus.in_b : bus.in_b;
  assign c0_in  = bus.in_sub ? ~bus.in_cin : bus.in_cin;
  assign p_in   = bus.in_a ^ b_cond;
  assign g_in   = bus.in_a & b_cond;

  for (genvar k = 0; k < NB; k++) begin : g_s1_blk
    // Only the group terms are needed here. The block carries are recomputed in stage 2.
    logic [BLOCK-1:0] unused_c;
    cla_block4 #(.BLOCK(BLOCK)) u_blk (
      .p_i     (p_in[k*BLOCK +: BLOCK]),
      .g_i     (g_in[k*BLOCK +: BLOCK]),
      .cin_i   (1'b0),
      .c_o     (unused_c),
      .grp_p_o (grp_p_in[k]),
      .grp_g_o (grp_g_in[k])
    );
  end

  always_comb begin
    s1_d       = '0;
    s1_d.p     = CLA_MAX_W'(p_in);
    s1_d.g     = CLA_MAX_W'(g_in);
    s1_d.grp_p = CLA_MAX_NB'(grp_p_in);
    s1_d.grp_g = CLA_MAX_NB'(grp_g_in);
    s1_d.c0    = c0_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (adv1) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) s1_q <= s1_d;
    end
  end

  // ---------------- stage 2: block carries, then in-block carries ----------------
  logic [CLA_MAX_NB:0] blk_c;   // blk_c[k] is the carry into block k; blk_c[NB] is the carry-out
  logic [WIDTH:0]      bit_c;   // bit_c[i] is the carry into bit i
  logic                unused_s1;

  // The padding bits above NB are zero, so the unused block carries do not matter.
  assign blk_c = cla_carries(s1_q.grp_p, s1_q.grp_g, s1_q.c0);

  for (genvar k = 0; k < NB; k++) begin : g_s2_blk
    logic [CLA_MAX_NB:0] c_loc;
    logic                unused_c_hi;
    assign c_loc = cla_carries(CLA_MAX_NB'(s1_q.p[k*BLOCK +: BLOCK]),
                               CLA_MAX_NB'(s1_q.g[k*BLOCK +: BLOCK]),
                               blk_c[k]);
    assign bit_c[k*BLOCK +: BLOCK] = c_loc[BLOCK-1:0];
    assign unused_c_hi = ^c_loc[CLA_MAX_NB:BLOCK];
  end
  assign bit_c[WIDTH] = blk_c[NB];

  assign unused_s1 = ^{s1_q, blk_c};

  assign out_sum_d  = s1_q.p[WIDTH-1:0] ^ bit_c[WIDTH-1:0];
  assign out_cout_d = bit_c[WIDTH];
  assign out_ovf_d  = bit_c[WIDTH-1] ^ bit_c[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sum_q  <= out_sum_d;
        out_cout_q <= out_cout_d;
        out_ovf_q  <= out_ovf_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
`timescale 1ns/1ps
// Directed and scoreboarded bench for cla_addsub_pipe (WIDTH=16) plus a single-block WIDTH=4 instance.
// Result words are packed as {sum, cout, ovf}.
module tb_cla_addsub_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla_addsub_pipe_if #(.WIDTH(16)) bus ();
  cla_addsub_pipe_if #(.WIDTH(4))  bus4 ();

  cla_addsub_pipe #(.WIDTH(16), .BLOCK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  cla_addsub_pipe #(.WIDTH(4), .BLOCK(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;  bus.in_a  = '0; bus.in_b  = '0;
    bus.in_cin     = 1'b0;  bus.in_sub = 1'b0; bus.out_ready = 1'b1;
    bus4.in_valid  = 1'b0;  bus4.in_a = '0; bus4.in_b = '0;
    bus4.in_cin    = 1'b0;  bus4.in_sub = 1'b0; bus4.out_ready = 1'b1;
  endtask

  // Drives one beat into the idle 16-bit pipe. It returns the first result seen and the number of edges
  // from presenting the beat to out_valid. edges = 0 means nothing appeared within the budget.
  task automatic run_beat(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                          output logic [17:0] res, output int edges);
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    res = '0; edges = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        res = {bus.out_sum, bus.out_cout, bus.out_ovf};
        edges = i;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    tests_run++;
    if ({bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf} !== 19'b0) begin
      tests_failed++;
      $display("FAIL reset_out: got %b, required all zero", {bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf});
    end
    tests_run++;
    if ({bus4.out_valid, bus4.out_sum, bus4.out_cout, bus4.out_ovf} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_out4: got %b, required all zero", {bus4.out_valid, bus4.out_sum, bus4.out_cout, bus4.out_ovf});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [15:0] ta [3] = '{16'h1234, 16'hAAAA, 16'h00FF};
    logic [15:0] tb [3] = '{16'h4321, 16'h5555, 16'h0F01};
    logic        tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [17:0] te [3] = '{{16'h5555, 2'b00}, {16'h0000, 2'b10}, {16'h1000, 2'b00}};
    logic [17:0] res;
    int          edges;
    for (int i = 0; i < 3; i++) begin
      run_beat(ta[i], tb[i], tc[i], 1'b0, res, edges);
      tests_run++;
      if (res !== te[i]) begin
        tests_failed++;
        $display("FAIL add_%0d: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                 i, res[17:2], res[1], res[0], te[i][17:2], te[i][1], te[i][0]);
      end
      tests_run++;
      if (edges != 2) begin
        tests_failed++;
        $display("FAIL add_latency_%0d: got %0d edges, required 2", i, edges);
      end
    end
  endtask

  task automatic test_sub();
    logic [15:0] ta [3] = '{16'h0005, 16'h8000, 16'h1234};
    logic [15:0] tb [3] = '{16'h0007, 16'h0001, 16'h1234};
    logic        tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [17:0] te [3] = '{{16'hFFFE, 2'b00}, {16'h7FFF, 2'b11}, {16'hFFFF, 2'b00}};
    logic [17:0] res;
    int          edges;
    for (int i = 0; i < 3; i++) begin
      run_beat(ta[i], tb[i], tc[i], 1'b1, res, edges);
      tests_run++;
      if (res !== te[i]) begin
        tests_failed++;
        $display("FAIL sub_%0d: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                 i, res[17:2], res[1], res[0], te[i][17:2], te[i][1], te[i][0]);
      end
    end
  endtask

  task automatic test_boundary();
    logic [17:0] res;
    int          edges;
    run_beat(16'hFFFF, 16'h0000, 1'b1, 1'b0, res, edges);
    tests_run++;
    if (res !== {16'h0000, 2'b10}) begin
      tests_failed++;
      $display("FAIL full_propagate: got %h/%b/%b, required 0000/1/0", res[17:2], res[1], res[0]);
    end
    run_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, res, edges);
    tests_run++;
    if (res !== {16'h8000, 2'b01}) begin
      tests_failed++;
      $display("FAIL pos_overflow: got %h/%b/%b, required 8000/0/1", res[17:2], res[1], res[0]);
    end
  endtask

  task automatic test_nb1();
    logic [3:0] ta [3] = '{4'hF, 4'h7, 4'h3};
    logic [3:0] tb [3] = '{4'h0, 4'h1, 4'h5};
    logic       tc [3] = '{1'b1, 1'b0, 1'b0};
    logic       ts [3] = '{1'b0, 1'b0, 1'b1};
    logic [6:0] te [3] = '{{1'b1, 4'h0, 2'b10}, {1'b1, 4'h8, 2'b01}, {1'b1, 4'hE, 2'b00}};
    logic [6:0] got;
    for (int i = 0; i < 3; i++) begin
      bus4.in_a = ta[i]; bus4.in_b = tb[i]; bus4.in_cin = tc[i]; bus4.in_sub = ts[i];
      bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      @(posedge clk); #1;
      got = {bus4.out_valid, bus4.out_sum, bus4.out_cout, bus4.out_ovf};
      tests_run++;
      if (got !== te[i]) begin
        tests_failed++;
        $display("FAIL nb1_%0d: got vld/sum/cout/ovf=%b, required %b", i, got, te[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int          sent = 0;
    int          first = -1;
    int          last = -1;
    logic        accept;
    logic [15:0] res [$];
    logic [15:0] exp [4] = '{16'd2, 16'd4, 16'd6, 16'd8};
    for (int cyc = 0; cyc < 14; cyc++) begin
      bus.out_ready = (cyc >= 5);
      bus.in_valid  = (sent < 4);
      bus.in_a      = 16'(sent + 1);
      bus.in_b      = 16'(sent + 1);
      bus.in_cin    = 1'b0;
      bus.in_sub    = 1'b0;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        tests_run++;
        if ({bus.in_ready, bus.out_valid, bus.out_sum} !== {1'b0, 1'b1, 16'd2} || sent != 2) begin
          tests_failed++;
          $display("FAIL stall_cyc%0d: got in_ready=%b out_valid=%b sum=%h accepted=%0d, required 0/1/0002/2",
                   cyc, bus.in_ready, bus.out_valid, bus.out_sum, sent);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        res.push_back(bus.out_sum);
        if (first < 0) first = cyc;
        last = cyc;
      end
      accept = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (accept) sent++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tests_run++;
    if (res.size() != 4) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d results, required 4", res.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (res[i] !== exp[i]) begin
          tests_failed++;
          $display("FAIL bp_order_%0d: got %h, required %h", i, res[i], exp[i]);
        end
      end
    end
    tests_run++;
    if (first != 5 || last != 8) begin
      tests_failed++;
      $display("FAIL bp_rate: got results on cycles %0d..%0d, required 5..8", first, last);
    end
  endtask

  task automatic test_reset_midflight();
    logic [17:0] res;
    int          edges;
    bus.out_ready = 1'b0;
    bus.in_sub = 1'b0; bus.in_cin = 1'b0;
    bus.in_a = 16'h0009; bus.in_b = 16'h0009; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_a = 16'h0007; bus.in_b = 16'h0007;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    tests_run++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL mid_full: got out_valid=%b in_ready=%b, required 1/0", bus.out_valid, bus.in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.out_valid, bus.out_sum} !== 17'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_async: got out_valid=%b sum=%h, required 0/0000", bus.out_valid, bus.out_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    run_beat(16'h0001, 16'h0001, 1'b0, 1'b0, res, edges);
    tests_run++;
    if (res !== {16'h0002, 2'b00} || edges != 2) begin
      tests_failed++;
      $display("FAIL post_reset_beat: got sum=%h cout=%b ovf=%b after %0d edges, required 0002/0/0 after 2",
               res[17:2], res[1], res[0], edges);
    end
  endtask

  task automatic test_random();
    logic [17:0] expq [$];
    logic [17:0] exp_r, got, held;
    logic [15:0] bp;
    logic        c0, ovf, stalled;
    logic [16:0] full;
    int          sent = 0;
    int          cyc  = 0;
    stalled = 1'b0; held = '0;
    while ((sent < 2000 || expq.size() > 0) && cyc < 20000) begin
      bus.in_valid  = (sent < 2000) && ($urandom_range(0, 3) != 0);
      bus.in_a      = 16'($urandom);
      bus.in_b      = 16'($urandom);
      bus.in_cin    = 1'($urandom);
      bus.in_sub    = 1'($urandom);
      bus.out_ready = (sent >= 2000) || ($urandom_range(0, 3) != 0);
      #1;
      got = {bus.out_sum, bus.out_cout, bus.out_ovf};
      if (stalled) begin
        tests_run++;
        if (!bus.out_valid || got !== held) begin
          tests_failed++;
          $display("FAIL rand_stall_hold: got vld=%b %h, required vld=1 %h", bus.out_valid, got, held);
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held = got;
      if (bus.out_valid && bus.out_ready) begin
        tests_run++;
        if (expq.size() == 0) begin
          tests_failed++;
          $display("FAIL rand_extra: got unexpected result %h, required none", got);
        end else begin
          exp_r = expq.pop_front();
          if (got !== exp_r) begin
            tests_failed++;
            $display("FAIL rand_beat: got %h, required %h", got, exp_r);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        bp   = bus.in_sub ? ~bus.in_b : bus.in_b;
        c0   = bus.in_sub ? ~bus.in_cin : bus.in_cin;
        full = {1'b0, bus.in_a} + {1'b0, bp} + {16'b0, c0};
        ovf  = (bus.in_a[15] == bp[15]) && (full[15] != bus.in_a[15]);
        expq.push_back({full[15:0], full[16], ovf});
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tests_run++;
    if (sent != 2000 || expq.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_drain: got sent=%0d pending=%0d, required 2000/0", sent, expq.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_boundary();
    test_nb1();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
